// File: rtl/triangle_scan_pkg.sv
// Shared types for the triangle raster-scan feeder.
package triangle_scan_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [1:0] {
    IDLE,
    BBOX,
    SCAN
  } state_t;

endpackage

// File: rtl/triangle_scan_min_max3.sv
// Combinational unsigned min and max of three coordinates.
module triangle_scan_min_max3
  import triangle_scan_pkg::*;
(
  input  coord_t a,
  input  coord_t b,
  input  coord_t c,
  output coord_t lo,
  output coord_t hi
);

  coord_t ab_lo;
  coord_t ab_hi;

  assign ab_lo = (a < b) ? a : b;
  assign ab_hi = (a < b) ? b : a;
  assign lo    = (c < ab_lo) ? c : ab_lo;
  assign hi    = (c > ab_hi) ? c : ab_hi;

endmodule

// File: rtl/triangle_scan.sv
// Accepts a triangle, computes its bounding box and streams every integer
// point of the box row-major, together with the latched vertices.
module triangle_scan
  import triangle_scan_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tri_valid,
  output logic         tri_ready,
  input  logic [W-1:0] tri_xa,
  input  logic [W-1:0] tri_ya,
  input  logic [W-1:0] tri_xb,
  input  logic [W-1:0] tri_yb,
  input  logic [W-1:0] tri_xc,
  input  logic [W-1:0] tri_yc,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [W-1:0] pt_x,
  output logic [W-1:0] pt_y,
  output logic         pt_last,
  output logic [W-1:0] v_xa,
  output logic [W-1:0] v_ya,
  output logic [W-1:0] v_xb,
  output logic [W-1:0] v_yb,
  output logic [W-1:0] v_xc,
  output logic [W-1:0] v_yc,
  output logic         busy,
  output logic         done
);

  state_t state, state_nx;
  point_t lo, hi, cur;
  coord_t xmin_c, xmax_c, ymin_c, ymax_c;
  coord_t x_inc, y_inc;
  logic   hs, at_xmax, at_ymax;

  // Box limits come straight from the latched vertices, consumed in BBOX.
  triangle_scan_min_max3 u_mm_x (.a(v_xa), .b(v_xb), .c(v_xc), .lo(xmin_c), .hi(xmax_c));
  triangle_scan_min_max3 u_mm_y (.a(v_ya), .b(v_yb), .c(v_yc), .lo(ymin_c), .hi(ymax_c));

  assign hs        = pt_valid && pt_ready;
  assign at_xmax   = (cur.x == hi.x);
  assign at_ymax   = (cur.y == hi.y);
  // Only used when not yet at the limit, so these never wrap.
  assign x_inc     = cur.x + 1'b1;
  assign y_inc     = cur.y + 1'b1;
  assign pt_x      = cur.x;
  assign pt_y      = cur.y;
  assign tri_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: accept, one box cycle, then scan until the last handshake.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tri_valid) state_nx = BBOX;
      BBOX:    state_nx = SCAN;
      SCAN:    if (hs && at_xmax && at_ymax) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Vertex latch, box registers and point counters; everything holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_xa <= '0; v_ya <= '0; v_xb <= '0; v_yb <= '0; v_xc <= '0; v_yc <= '0;
      lo <= '0; hi <= '0; cur <= '0;
      pt_valid <= 1'b0;
      pt_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (tri_valid) begin
          v_xa <= tri_xa; v_ya <= tri_ya;
          v_xb <= tri_xb; v_yb <= tri_yb;
          v_xc <= tri_xc; v_yc <= tri_yc;
        end
        BBOX: begin
          lo.x     <= xmin_c; lo.y <= ymin_c;
          hi.x     <= xmax_c; hi.y <= ymax_c;
          cur.x    <= xmin_c; cur.y <= ymin_c;
          pt_valid <= 1'b1;
          pt_last  <= (xmin_c == xmax_c) && (ymin_c == ymax_c);
        end
        SCAN: if (hs) begin
          if (!at_xmax) begin
            cur.x   <= x_inc;
            pt_last <= at_ymax && (x_inc == hi.x);
          end else if (!at_ymax) begin
            cur.x   <= lo.x;
            cur.y   <= y_inc;
            pt_last <= (lo.x == hi.x) && (y_inc == hi.y);
          end else begin
            pt_valid <= 1'b0;
            pt_last  <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_scan.sv
// Directed bench for triangle_scan with a queue-based point model.
module tb_triangle_scan;
  import triangle_scan_pkg::*;

  localparam int W = COORD_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         tri_valid, tri_ready;
  logic [W-1:0] tri_xa, tri_ya, tri_xb, tri_yb, tri_xc, tri_yc;
  logic         pt_valid, pt_ready, pt_last;
  logic [W-1:0] pt_x, pt_y;
  logic [W-1:0] v_xa, v_ya, v_xb, v_yb, v_xc, v_yc;
  logic         busy, done;

  always #5 clk = ~clk;

  triangle_scan #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_xa(tri_xa), .tri_ya(tri_ya), .tri_xb(tri_xb),
    .tri_yb(tri_yb), .tri_xc(tri_xc), .tri_yc(tri_yc),
    .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
    .v_xa(v_xa), .v_ya(v_ya), .v_xb(v_xb),
    .v_yb(v_yb), .v_xc(v_xc), .v_yc(v_yc),
    .busy(busy), .done(done)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model state: points still owed by the DUT, vertices of the triangle in flight.
  point_t       exp_q[$];
  logic [W-1:0] ev[6];
  logic         exp_done = 1'b0;
  bit           chk_en = 1'b0;
  bit           rdy_toggle = 1'b0;
  int           cyc = 0;
  int           n_hs = 0;

  function automatic int mn3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int mx3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic void push_tri(input logic [W-1:0] xa, ya, xb, yb, xc, yc);
    int x0, x1, y0, y1;
    point_t p;
    x0 = mn3(int'(xa), int'(xb), int'(xc));
    x1 = mx3(int'(xa), int'(xb), int'(xc));
    y0 = mn3(int'(ya), int'(yb), int'(yc));
    y1 = mx3(int'(ya), int'(yb), int'(yc));
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        p.x = coord_t'(x);
        p.y = coord_t'(y);
        exp_q.push_back(p);
      end
    ev[0] = xa; ev[1] = ya; ev[2] = xb; ev[3] = yb; ev[4] = xc; ev[5] = yc;
  endfunction

  // Downstream ready: constant high or the 1,0,0,1 pattern.
  always @(posedge clk) begin
    #1;
    cyc++;
    pt_ready = rdy_toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  // Per-cycle compare against the model.
  point_t prev;
  bit     prev_stall = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done", done, exp_done);
      if (pt_valid) begin
        chk("point_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("pt_x", pt_x, exp_q[0].x);
          chk("pt_y", pt_y, exp_q[0].y);
          chk("pt_last", pt_last, exp_q.size() == 1);
          chk("v_xa", v_xa, ev[0]); chk("v_ya", v_ya, ev[1]);
          chk("v_xb", v_xb, ev[2]); chk("v_yb", v_yb, ev[3]);
          chk("v_xc", v_xc, ev[4]); chk("v_yc", v_yc, ev[5]);
        end
      end
      if (prev_stall) begin
        chk("stall_hold_x", pt_x, prev.x);
        chk("stall_hold_y", pt_y, prev.y);
      end
      prev_stall = pt_valid && !pt_ready;
      prev.x = pt_x;
      prev.y = pt_y;
      if (rst) begin
        exp_q.delete();
        exp_done   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        exp_done = pt_valid && pt_ready && (exp_q.size() == 1);
        if (pt_valid && pt_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_hs++;
        end
      end
    end
  end

  task automatic send_tri(input logic [W-1:0] xa, ya, xb, yb, xc, yc, output bit acc_done);
    bit acc;
    acc = 1'b0;
    acc_done = 1'b0;
    @(posedge clk); #1;
    tri_xa = xa; tri_ya = ya; tri_xb = xb; tri_yb = yb; tri_xc = xc; tri_yc = yc;
    tri_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tri_ready) begin
        push_tri(xa, ya, xb, yb, xc, yc);
        acc_done = done;
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    tri_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) chk({name, "_done_timeout"}, 0, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int h0;
    bit awd;
    bit hit;
    rst = 1'b1; tri_valid = 1'b0; pt_ready = 1'b1;
    tri_xa = '0; tri_ya = '0; tri_xb = '0; tri_yb = '0; tri_xc = '0; tri_yc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_last", pt_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tri_ready", tri_ready, 1);
    chk("rst_pt_xy", {pt_x, pt_y}, 0);
    chk("rst_v", {v_xa, v_ya, v_xb}, 0);
    chk("rst_v2", {v_yb, v_xc, v_yc}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: right triangle, ready always high, latency check.
    h0 = n_hs;
    send_tri(10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd2, awd);
    chk("s1_model_size", exp_q.size(), 12);
    chk("s1_model_q4", exp_q[4], {10'd0, 10'd1});
    chk("s1_model_last", exp_q[11], {10'd3, 10'd2});
    @(negedge clk);
    chk("s1_bbox_valid", pt_valid, 0);
    chk("s1_bbox_busy", busy, 1);
    chk("s1_bbox_ready", tri_ready, 0);
    @(negedge clk);
    chk("s1_first_valid", pt_valid, 1);
    chk("s1_first_xy", {pt_x, pt_y}, {10'd0, 10'd0});
    wait_done("s1");
    chk("s1_done_ready", tri_ready, 1);
    chk("s1_done_busy", busy, 0);
    chk("s1_count", n_hs - h0, 12);

    // 2: same triangle with back-pressure.
    rdy_toggle = 1'b1;
    h0 = n_hs;
    send_tri(10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd2, awd);
    wait_done("s2");
    chk("s2_count", n_hs - h0, 12);
    rdy_toggle = 1'b0;

    // 3: all vertices equal.
    h0 = n_hs;
    send_tri(10'd5, 10'd7, 10'd5, 10'd7, 10'd5, 10'd7, awd);
    chk("s3_model_size", exp_q.size(), 1);
    wait_done("s3");
    chk("s3_count", n_hs - h0, 1);

    // 4: top corner of the coordinate range.
    h0 = n_hs;
    send_tri(10'd1021, 10'd1020, 10'd1023, 10'd1023, 10'd1022, 10'd1021, awd);
    chk("s4_model_size", exp_q.size(), 12);
    chk("s4_model_last", exp_q[11], {10'd1023, 10'd1023});
    wait_done("s4");
    chk("s4_count", n_hs - h0, 12);

    // 5: reset while the fourth point is presented.
    h0 = n_hs;
    send_tri(10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd2, awd);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (n_hs - h0 == 3) begin hit = 1'b1; break; end
    end
    if (!hit) chk("s5_reach_point4", 0, 1);
    chk("s5_at_point4", {pt_x, pt_y}, {10'd3, 10'd0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_pt_valid", pt_valid, 0);
    chk("s5_busy", busy, 0);
    chk("s5_tri_ready", tri_ready, 1);
    chk("s5_no_done", done, 0);
    h0 = n_hs;
    send_tri(10'd2, 10'd3, 10'd4, 10'd3, 10'd3, 10'd5, awd);
    chk("s5_model_size", exp_q.size(), 9);
    wait_done("s5");
    chk("s5_count", n_hs - h0, 9);

    // 6: second triangle held on the input during the first scan.
    h0 = n_hs;
    send_tri(10'd0, 10'd0, 10'd3, 10'd0, 10'd0, 10'd2, awd);
    send_tri(10'd10, 10'd20, 10'd12, 10'd20, 10'd11, 10'd21, awd);
    chk("s6_accept_on_done", awd, 1);
    wait_done("s6");
    chk("s6_count", n_hs - h0, 18);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
